// File: rtl/rom_mapper_detect.sv
// Heuristic cartridge mapper detector: scans the downloaded ROM byte stream for
// LD (nn),A bank-switch writes, votes per mapper and reports the winner at rom_done.
module rom_mapper_detect #(
    parameter logic [23:0] SMALL_LIMIT = 24'h010000,
    parameter int          CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rom_start,
    input  logic        rom_wr,
    input  logic [7:0]  rom_data,
    input  logic        rom_done,
    output logic        busy,
    output logic        valid,
    output logic [5:0]  mapper,
    output logic [23:0] rom_size
);

    localparam logic [5:0] MAPPER_NO_UNKNOWN = 6'd0;
    localparam logic [5:0] MAPPER_ASCII8     = 6'd1;
    localparam logic [5:0] MAPPER_ASCII16    = 6'd2;
    localparam logic [5:0] MAPPER_KONAMI     = 6'd3;
    localparam logic [5:0] MAPPER_KONAMI_SCC = 6'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_LO     = 3'd2,
        ST_HI     = 3'd3,
        ST_DECIDE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t            state_r;
    logic [7:0]        lo_r;
    logic              vote_r;
    logic [15:0]       vote_addr_r;
    logic [CNT_W-1:0]  cnt_scc_r, cnt_kon_r, cnt_a8_r, cnt_a16_r;
    logic [CNT_W-1:0]  nxt_scc_s, nxt_kon_s, nxt_a8_s, nxt_a16_s;
    logic              hit_scc_s, hit_kon_s, hit_a8_s, hit_a16_s;
    logic [23:0]       rom_size_r;
    logic              busy_r, valid_r;
    logic [5:0]        mapper_r;
    logic              scanning_s;
    logic [CNT_W-1:0]  best1_s, best2_s, best3_s;
    logic [5:0]        map1_s, map2_s, map3_s, decision_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
        return (hit && (v != CNT_MAX)) ? (v + CNT_ONE) : v;
    endfunction

    assign scanning_s = (state_r == ST_SCAN) || (state_r == ST_LO) || (state_r == ST_HI);

    // Decode the registered bank-switch address into per-mapper votes.
    always_comb begin
        hit_scc_s = 1'b0;
        hit_kon_s = 1'b0;
        hit_a8_s  = 1'b0;
        hit_a16_s = 1'b0;
        if (vote_r) begin
            case (vote_addr_r)
                16'h4000, 16'h8000, 16'hA000: hit_kon_s = 1'b1;
                16'h5000, 16'h9000, 16'hB000: hit_scc_s = 1'b1;
                16'h6000: begin
                    hit_kon_s = 1'b1;
                    hit_a8_s  = 1'b1;
                    hit_a16_s = 1'b1;
                end
                16'h6800, 16'h7800: hit_a8_s = 1'b1;
                16'h7000: begin
                    hit_scc_s = 1'b1;
                    hit_a8_s  = 1'b1;
                    hit_a16_s = 1'b1;
                end
                16'h77FF: hit_a16_s = 1'b1;
                default: hit_scc_s = 1'b0;
            endcase
        end else begin
            hit_scc_s = 1'b0;
        end
    end

    // Next counter values; the decision looks at these so a vote pending at rom_done still counts.
    always_comb begin
        nxt_scc_s = sat_inc(cnt_scc_r, hit_scc_s);
        nxt_kon_s = sat_inc(cnt_kon_r, hit_kon_s);
        nxt_a8_s  = sat_inc(cnt_a8_r,  hit_a8_s);
        nxt_a16_s = sat_inc(cnt_a16_r, hit_a16_s);
    end

    // Largest counter wins; strict comparisons keep the earlier (higher-priority) mapper on ties.
    always_comb begin
        best1_s    = (nxt_kon_s > nxt_scc_s) ? nxt_kon_s : nxt_scc_s;
        map1_s     = (nxt_kon_s > nxt_scc_s) ? MAPPER_KONAMI : MAPPER_KONAMI_SCC;
        best2_s    = (nxt_a8_s > best1_s) ? nxt_a8_s : best1_s;
        map2_s     = (nxt_a8_s > best1_s) ? MAPPER_ASCII8 : map1_s;
        best3_s    = (nxt_a16_s > best2_s) ? nxt_a16_s : best2_s;
        map3_s     = (nxt_a16_s > best2_s) ? MAPPER_ASCII16 : map2_s;
        decision_s = ((rom_size_r <= SMALL_LIMIT) || (best3_s == CNT_ZERO)) ? MAPPER_NO_UNKNOWN : map3_s;
    end

    // Detection FSM, byte counter, vote counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            lo_r        <= 8'h00;
            vote_r      <= 1'b0;
            vote_addr_r <= 16'h0000;
            cnt_scc_r   <= CNT_ZERO;
            cnt_kon_r   <= CNT_ZERO;
            cnt_a8_r    <= CNT_ZERO;
            cnt_a16_r   <= CNT_ZERO;
            rom_size_r  <= 24'h000000;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            mapper_r    <= MAPPER_NO_UNKNOWN;
        end else if (rom_start) begin
            state_r    <= ST_SCAN;
            vote_r     <= 1'b0;
            cnt_scc_r  <= CNT_ZERO;
            cnt_kon_r  <= CNT_ZERO;
            cnt_a8_r   <= CNT_ZERO;
            cnt_a16_r  <= CNT_ZERO;
            rom_size_r <= 24'h000000;
            busy_r     <= 1'b1;
            valid_r    <= 1'b0;
        end else begin
            cnt_scc_r <= nxt_scc_s;
            cnt_kon_r <= nxt_kon_s;
            cnt_a8_r  <= nxt_a8_s;
            cnt_a16_r <= nxt_a16_s;
            vote_r    <= 1'b0;
            if (scanning_s && rom_wr && (rom_size_r != 24'hFFFFFF)) begin
                rom_size_r <= rom_size_r + 24'd1;
            end
            case (state_r)
                ST_SCAN: begin
                    if (rom_wr && (rom_data == 8'h32)) state_r <= ST_LO;
                    if (rom_done) state_r <= ST_DECIDE;
                end
                ST_LO: begin
                    if (rom_wr) begin
                        lo_r    <= rom_data;
                        state_r <= ST_HI;
                    end
                    if (rom_done) state_r <= ST_DECIDE;
                end
                ST_HI: begin
                    if (rom_wr) begin
                        vote_r      <= 1'b1;
                        vote_addr_r <= {rom_data, lo_r};
                        state_r     <= ST_SCAN;
                    end
                    if (rom_done) state_r <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    mapper_r <= decision_s;
                    valid_r  <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= ST_DONE;
                end
                ST_IDLE: state_r <= ST_IDLE;
                ST_DONE: state_r <= ST_DONE;
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign valid    = valid_r;
    assign mapper   = mapper_r;
    assign rom_size = rom_size_r;

endmodule

// File: doc/rom_mapper_detect.md
# rom_mapper_detect

Heuristic cartridge mapper detector. It watches the ROM image byte stream as it is written into SDRAM during a cartridge download and votes on bank-switch write addresses. When the download ends it reports a `MAPPER_*` code. It produces the mapper selection that the cartridge mapper decoders consume; the core falls back to it when the user selects automatic mapper mode.

## Interface
Parameters:
- `SMALL_LIMIT`, default 24'h010000: images of this many bytes or fewer report `MAPPER_NO_UNKNOWN` (plain, unmapped).
- `CNT_W`, default 16: width of each vote counter.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rom_start`  in  1  single-cycle pulse marking the start of a download.
- `rom_wr`  in  1  the byte on `rom_data` is valid this cycle.
- `rom_data`  in  8  image byte, in ascending address order.
- `rom_done`  in  1  single-cycle pulse marking the end of a download.
- `busy`  out  1  high while a detection is in progress.
- `valid`  out  1  `mapper` is final; held until the next `rom_start` or `reset`.
- `mapper`  out  6  detected code: `MAPPER_NO_UNKNOWN`, `MAPPER_ASCII8`, `MAPPER_ASCII16`, `MAPPER_KONAMI` or `MAPPER_KONAMI_SCC`.
- `rom_size`  out  24  bytes accepted; saturates at 24'hFFFFFF.

## Operation
- States: IDLE, SCAN, LO, HI, DECIDE, DONE. Reset goes to IDLE.
- IDLE and DONE: `rom_wr` and `rom_done` are ignored.
- `rom_start` in any state except during `reset`:
  - Clears all counters, `rom_size` and `valid`, and enters SCAN.
  - A `rom_wr` in the same cycle is discarded.
- Byte handling on each accepted `rom_wr`:
  - `rom_size` increments by 1, saturating.
  - SCAN: byte 8'h32 (the `LD (nn),A` opcode) moves to LO; any other byte stays in SCAN.
  - LO: the byte is stored as the address low byte; move to HI.
  - HI: the address is formed as {byte, lo}. A vote strobe is registered and the state returns to SCAN.
  - Patterns do not overlap: operand bytes are never rechecked as opcodes.
- Votes are applied one cycle after the HI byte. Counters saturate at all-ones.
  - 16'h4000, 8000, A000: KONAMI +1.
  - 16'h5000, 9000, B000: SCC +1.
  - 16'h6000: KONAMI, ASCII8 and ASCII16 each +1.
  - 16'h6800, 7800: ASCII8 +1.
  - 16'h7000: SCC, ASCII8 and ASCII16 each +1.
  - 16'h77FF: ASCII16 +1.
  - Any other address: no change.
- `rom_done` in SCAN, LO or HI moves to DECIDE. A partial LO/HI pattern is dropped.
- DECIDE: one cycle, computes the result and moves to DONE.
  - `rom_size` ≤ `SMALL_LIMIT`: result is `MAPPER_NO_UNKNOWN`.
  - Otherwise the counter with the largest value wins, by unsigned comparison.
  - Ties resolve by priority: KONAMI_SCC > KONAMI > ASCII8 > ASCII16.
  - All counters zero: result is `MAPPER_NO_UNKNOWN`.
- DONE: `mapper` and `valid` are held, `busy` is 0.

## Timing
- Reset values: `busy`=0, `valid`=0, `mapper`=`MAPPER_NO_UNKNOWN`, `rom_size`=0, all counters 0.
- `busy` rises the cycle after `rom_start` and falls in the same cycle `valid` rises.
- Byte stream: `rom_wr` may be asserted every cycle; there is no backpressure.
- Vote latency: the counter updates at edge N+1 after the HI byte at edge N.
- `rom_done` at edge N: any pending vote is applied at N+1, DECIDE runs at N+1, and `mapper`/`valid` are registered at N+2.
- `rom_wr` in the same cycle as `rom_done` is counted and scanned first. If it completes a pattern, that vote is included in the decision.
- `rom_start` during DECIDE or DONE: restarts immediately; `valid` drops the next cycle.
- `reset` overrides everything. `reset` in the middle of a download returns to IDLE with reset values.

## Test plan
- 128 KiB image with three copies of 32 00 60, three of 32 00 80 and one of 32 00 68, then zero padding -> `mapper`=`MAPPER_KONAMI` and `valid`=1 two cycles after `rom_done`; `rom_size`=24'h020000.
- 256 KiB image with 32 00 50, 32 00 70, 32 00 90 and 32 00 B0 -> `MAPPER_KONAMI_SCC` (SCC=4, ASCII8=1, ASCII16=1).
- 128 KiB image with 32 00 68, 32 00 78, 32 00 60 and 32 00 70 -> `MAPPER_ASCII8` (4 votes against 2); swap in 32 FF 77 twice instead of the 68/78 writes -> `MAPPER_ASCII16` (4 against 2).
- 32 KiB image containing ten 32 00 80 patterns -> `MAPPER_NO_UNKNOWN`; all-zero 128 KiB image -> `MAPPER_NO_UNKNOWN`. Overlap check: the byte run 32 32 00 80 yields no KONAMI vote.
- Tie and boundary cases:
  - One 32 00 50 and one 32 00 40 -> `MAPPER_KONAMI_SCC` on the tie.
  - `rom_done` in the same cycle as the final 80 byte of a pattern -> that vote is counted.
  - `rom_start` in the same cycle as a `rom_wr` -> the byte is discarded and `rom_size` reads 0 afterwards.
- `rom_start` mid-download, then a short image -> counters cleared and the fresh result is correct. `reset` mid-download -> all outputs return to reset values within one cycle; later `rom_done` pulses are ignored.
